// File: rtl/inv_aes_pkg.sv
// Shared definitions for the inverse-AES round datapath.
//   - state_t        : sequencer FSM encoding (IDLE/ISSUE/WAIT/DONE)
//   - NB_COL, COL_BITS, STATE_BITS : state geometry (4 columns of 32 bits)
//   - AES_POLY       : reduction constant for x^8+x^4+x^3+x+1
//   - IMC_C0..IMC_C3 : InvMixColumns coefficients 0e, 0b, 0d, 09
//   - gf_xtime/gf_mul: GF(2^8) arithmetic helpers
package inv_aes_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int NB_COL     = 4;
  localparam int COL_BITS   = 32;
  localparam int STATE_BITS = NB_COL * COL_BITS;

  localparam logic [7:0] AES_POLY = 8'h1b;
  localparam logic [7:0] IMC_C0   = 8'h0e;
  localparam logic [7:0] IMC_C1   = 8'h0b;
  localparam logic [7:0] IMC_C2   = 8'h0d;
  localparam logic [7:0] IMC_C3   = 8'h09;

  // Multiply by x: shift with 8-bit wrap, fold the overflowed MSB back in.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; only the set bits of b contribute.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_columns_sched_if.sv
// Handshake bundle between the round logic and the InvMixColumns sequencer.
//   in_valid/in_ready/in_data    : state into the sequencer
//   out_valid/out_ready/out_data : transformed state out of the sequencer
// Data is [0:STATE_BITS-1], column-major; column k = bits [32k : 32k+31].
//
// Valid/ready: a transfer happens on a rising clock edge where valid and
// ready are both 1. A producer holds valid and data stable until that edge;
// ready may be asserted independently of valid.
// modport slave  : the sequencer side
// modport master : the producer/consumer side driving the sequencer
interface inv_mix_columns_sched_if;
  import inv_aes_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [0:STATE_BITS-1] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:STATE_BITS-1] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_mix_column_pipe.sv
// Single-column InvMixColumns datapath: a combinational 32-bit transform
// followed by COL_LAT register stages. A valid bit and a 2-bit tag travel
// alongside the data so the caller can put each result back in its slot.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (valid/tag)
//   in_valid/in_tag/in_col : column issued this cycle
//   bypass              : pass the column through unmodified
//   out_valid/out_tag/out_col : column leaving the last stage
module inv_mix_column_pipe
  import inv_aes_pkg::*;
#(
  parameter int COL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [1:0]          in_tag,
  input  logic [COL_BITS-1:0] in_col,
  input  logic                bypass,
  output logic                out_valid,
  output logic [1:0]          out_tag,
  output logic [COL_BITS-1:0] out_col
);

  logic [COL_BITS-1:0] mixed;
  logic [7:0]          b0, b1, b2, b3;

  logic [COL_LAT-1:0]  vld_q;
  logic [1:0]          tag_q [COL_LAT];
  logic [COL_BITS-1:0] col_q [COL_LAT];

  // Byte 0 of a column is its most significant byte here.
  always_comb begin
    b0 = in_col[31:24];
    b1 = in_col[23:16];
    b2 = in_col[15:8];
    b3 = in_col[7:0];
    mixed = {
      gf_mul(b0, IMC_C0) ^ gf_mul(b1, IMC_C1) ^ gf_mul(b2, IMC_C2) ^ gf_mul(b3, IMC_C3),
      gf_mul(b1, IMC_C0) ^ gf_mul(b2, IMC_C1) ^ gf_mul(b3, IMC_C2) ^ gf_mul(b0, IMC_C3),
      gf_mul(b2, IMC_C0) ^ gf_mul(b3, IMC_C1) ^ gf_mul(b0, IMC_C2) ^ gf_mul(b1, IMC_C3),
      gf_mul(b3, IMC_C0) ^ gf_mul(b0, IMC_C1) ^ gf_mul(b1, IMC_C2) ^ gf_mul(b2, IMC_C3)
    };
    if (bypass) mixed = in_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < COL_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int i = 1; i < COL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Data stages need no reset: nothing downstream looks at them without valid.
  always_ff @(posedge clk) begin
    col_q[0] <= mixed;
    for (int i = 1; i < COL_LAT; i++) col_q[i] <= col_q[i-1];
  end

  assign out_valid = vld_q[COL_LAT-1];
  assign out_tag   = tag_q[COL_LAT-1];
  assign out_col   = col_q[COL_LAT-1];

endmodule

// File: rtl/inv_mix_columns_sched.sv
// Sequencer for InvMixColumns: accepts one 128-bit state, issues its four
// columns one per cycle into inv_mix_column_pipe, collects the results by tag
// and presents the full state on a valid/ready output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : inv_mix_columns_sched_if.slave (in_*/out_* handshakes)
//   bypass_i   : only with INV_MIX_COLUMNS_SCHED_BYPASS_EN; latched at accept,
//                1 = columns pass through unmodified with identical timing
//   busy       : a state is in flight (FSM not IDLE)
//   state_dbg  : current FSM state
// Optional feature macro: INV_MIX_COLUMNS_SCHED_BYPASS_EN
module inv_mix_columns_sched
  import inv_aes_pkg::*;
#(
  parameter int COL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inv_mix_columns_sched_if.slave  bus,
`ifdef INV_MIX_COLUMNS_SCHED_BYPASS_EN
  input  logic                    bypass_i,
`endif
  output logic                    busy,
  output state_t                  state_dbg
);

  state_t              state_q, state_d;
  logic [1:0]          col_cnt_q;
  logic                rst_done_q;
  logic [COL_BITS-1:0] col_buf [NB_COL];
  logic [COL_BITS-1:0] res_buf [NB_COL];
  logic                accept;
  logic                byp;

  logic                pipe_valid;
  logic [1:0]          pipe_tag;
  logic [COL_BITS-1:0] pipe_col;

  // rst_done_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready  = (state_q == IDLE) && rst_done_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = {res_buf[0], res_buf[1], res_buf[2], res_buf[3]};
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef INV_MIX_COLUMNS_SCHED_BYPASS_EN
  logic byp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      byp_q <= 1'b0;
    else if (accept) byp_q <= bypass_i;
  end
  assign byp = byp_q;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: if (col_cnt_q == 2'(NB_COL - 1)) state_d = WAIT;
      WAIT:  if (pipe_valid && pipe_tag == 2'(NB_COL - 1)) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      rst_done_q <= 1'b0;
      for (int k = 0; k < NB_COL; k++) begin
        col_buf[k] <= '0;
        res_buf[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      if (accept) begin
        col_cnt_q <= '0;
        for (int k = 0; k < NB_COL; k++) col_buf[k] <= bus.in_data[COL_BITS*k +: COL_BITS];
      end
      // Wraps back to 0 after the last column.
      if (state_q == ISSUE) col_cnt_q <= col_cnt_q + 2'd1;
      // With short COL_LAT results start landing while still issuing.
      if (pipe_valid) res_buf[pipe_tag] <= pipe_col;
    end
  end

  inv_mix_column_pipe #(.COL_LAT(COL_LAT)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_q == ISSUE),
    .in_tag    (col_cnt_q),
    .in_col    (col_buf[col_cnt_q]),
    .bypass    (byp),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .out_col   (pipe_col)
  );

endmodule

// File: tb/tb_inv_mix_columns_sched.sv
// Directed testbench for inv_mix_columns_sched (COL_LAT = 4).
// Define INV_MIX_COLUMNS_SCHED_BYPASS_EN to include the bypass vector.
module tb_inv_mix_columns_sched;
  import inv_aes_pkg::*;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_01010101_00000000;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_01010101_00000000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic busy;
  state_t state_dbg;
  logic bypass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_mix_columns_sched_if bus();

  inv_mix_columns_sched #(.COL_LAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
`ifdef INV_MIX_COLUMNS_SCHED_BYPASS_EN
    .bypass_i  (bypass),
`endif
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every completed output handshake must match the oldest expected state.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("stray_out", bus.out_valid, 1'b0);
      else                   check("sb_out_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    check(tag, bus.in_ready, 1'b1);
  endtask

  // Accept one state, check busy/out_valid on every cycle up to T+9, then
  // hold out_ready low for 'hold' cycles before completing the handshake.
  task automatic run_vector(input string tag, input logic [127:0] din,
                            input logic [127:0] exp, input logic byp, input int hold);
    wait_ready({tag, "_rdy"});
    exp_q.push_back(exp);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = din;
    bypass        = byp;
    step();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bypass        = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("%s_busy_t%0d", tag, k), busy, 1'b1);
      check($sformatf("%s_ovalid_t%0d", tag, k), bus.out_valid, (k == 9));
      check($sformatf("%s_irdy_t%0d", tag, k), bus.in_ready, 1'b0);
      if (k < 9) step();
    end
    check({tag, "_data"}, bus.out_data, exp);
    for (int h = 0; h < hold; h++) begin
      check($sformatf("%s_hold_valid%0d", tag, h), bus.out_valid, 1'b1);
      check($sformatf("%s_hold_data%0d", tag, h), bus.out_data, exp);
      check($sformatf("%s_hold_irdy%0d", tag, h), bus.in_ready, 1'b0);
      step();
    end
    bus.out_ready = 1'b1;
    check({tag, "_final_valid"}, bus.out_valid, 1'b1);
    step();
    check({tag, "_post_irdy"}, bus.in_ready, 1'b1);
    check({tag, "_post_busy"}, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bypass        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_state", state_dbg, IDLE);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", bus.in_ready, 1'b0);
    step();
    check("rel_in_ready_high", bus.in_ready, 1'b1);

    // Known vectors.
    run_vector("v1", V1_IN, V1_OUT, 1'b0, 0);
    run_vector("v2", V2_IN, V2_OUT, 1'b0, 0);

    // Backpressure: out_ready low for 5 cycles after out_valid.
    run_vector("bp", V2_IN, V2_OUT, 1'b0, 5);

    // Reset in the middle of an operation: the result must never appear.
    wait_ready("mid_rdy");
    bus.in_valid = 1'b1;
    bus.in_data  = V2_IN;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_rel_in_ready", bus.in_ready, 1'b1);
    check("mid_rel_out_valid", bus.out_valid, 1'b0);
    check("mid_rel_state", state_dbg, IDLE);
    run_vector("after_rst", V1_IN, V1_OUT, 1'b0, 0);

    // Back-to-back with in_valid held high.
    wait_ready("b2b_rdy");
    bus.out_ready = 1'b1;
    exp_q.push_back(V1_OUT);
    exp_q.push_back(V2_OUT);
    bus.in_valid = 1'b1;
    bus.in_data  = V1_IN;
    step();
    bus.in_data  = V2_IN;
    gap = 1;
    while (!bus.in_ready && gap < 30) begin
      step();
      gap++;
    end
    check("b2b_gap", gap, 10);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) step();
    check("b2b_drained", exp_q.size(), 0);

`ifdef INV_MIX_COLUMNS_SCHED_BYPASS_EN
    run_vector("bypass", V1_IN, V1_IN, 1'b1, 0);
    run_vector("bypass_off", V1_IN, V1_OUT, 1'b0, 0);
`endif

    repeat (3) step();
    check("end_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
